// File: rtl/pos_sweep_ctrl.sv
// pos_sweep_ctrl
//   Built-in self-check sequencer for a 3-input PoS datapath
//   (S1 = X^Y^Z, S2 = Y XNOR Z). On start, X/Y/Z step through 000..111.
//   Each vector is held for SETTLE_CYC cycles, then S1/S2 are sampled
//   and compared against internally computed expected values.
//
//   Start/abort semantics: start is a level sampled only in IDLE. There is
//   no ready/acknowledge signal; busy rising is the acceptance indication.
//   abort wins over start and over CHECK updates.
//
// Parameters
//   SETTLE_CYC   cycles each vector is held before sampling (1..15)
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start, abort sweep request / synchronous abort
//   S1, S2       datapath outputs under test
//   X, Y, Z      datapath inputs; {X,Y,Z} = current vector index
//   busy         sweep in progress (SETTLE/CHECK/DONE)
//   done         one-cycle pulse when a sweep completes
//   pass         no mismatch in the last completed sweep (held)
//   err_cnt      mismatching vectors in the current/last sweep (0..8)
//   fail_vec     bit i set = vector i mismatched
//   o_dbg_state  FSM state (0 IDLE, 1 SETTLE, 2 CHECK, 3 DONE)
module pos_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       S1,
  input  logic       S2,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_vec,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_pass;
  logic [3:0] r_err;
  logic [7:0] r_fv;

  logic       w_exp_s1;
  logic       w_exp_s2;
  logic       w_mis;
  logic       w_last;
  logic       w_accept;

  always_comb begin
    w_exp_s1 = r_idx[2] ^ r_idx[1] ^ r_idx[0];
    w_exp_s2 = ~(r_idx[1] ^ r_idx[0]);
    // Case inequality so an unknown on S1/S2 is reported as a mismatch.
    w_mis    = (S1 !== w_exp_s1) || (S2 !== w_exp_s2);
    w_last   = (r_idx == 3'd7);
    w_accept = start && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = SETTLE;
      SETTLE: begin
        if (abort)                 w_next = IDLE;
        else if (r_cnt == CNT_LAST) w_next = CHECK;
      end
      CHECK: begin
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = DONE;
        else             w_next = SETTLE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 3'd0;
      r_cnt  <= 4'd0;
      r_pass <= 1'b0;
      r_err  <= 4'd0;
      r_fv   <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx  <= 3'd0;
            r_cnt  <= 4'd0;
            r_pass <= 1'b0;
            r_err  <= 4'd0;
            r_fv   <= 8'd0;
          end
        end
        SETTLE: begin
          if (abort) r_pass <= 1'b0;
          else       r_cnt  <= r_cnt + 4'd1;
        end
        CHECK: begin
          if (abort) begin
            r_pass <= 1'b0;
          end else begin
            if (w_mis) begin
              r_fv[r_idx] <= 1'b1;
              r_err       <= r_err + 4'd1;
            end
            // The final verdict must include this cycle's own comparison.
            if (w_last) begin
              r_pass <= (r_err == 4'd0) && !w_mis;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_cnt <= 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // idx is registered, so X/Y/Z come straight from flops and hold 111 after DONE.
  assign X           = r_idx[2];
  assign Y           = r_idx[1];
  assign Z           = r_idx[0];
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign pass        = r_pass;
  assign err_cnt     = r_err;
  assign fail_vec    = r_fv;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pos_sweep_ctrl.sv
// Testbench for pos_sweep_ctrl: one instance with SETTLE_CYC=1 (A, with a
// fault-injectable PoS model) and one with SETTLE_CYC=4 (B, golden model).
module tb_pos_sweep_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, start_b, abort;
  logic s1_a, s2_a, s1_b, s2_b;
  logic x_a, y_a, z_a, busy_a, done_a, pass_a;
  logic x_b, y_b, z_b, busy_b, done_b, pass_b;
  logic [3:0] err_a, err_b;
  logic [7:0] fv_a, fv_b;
  logic [1:0] st_a, st_b;

  int mode;      // fault mode applied to instance A's datapath model
  int sel;       // 0 = observe A, 1 = observe B
  int n_cmp = 0;
  int n_mis = 0;

  pos_sweep_ctrl #(.SETTLE_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort),
    .S1(s1_a), .S2(s2_a), .X(x_a), .Y(y_a), .Z(z_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .fail_vec(fv_a), .o_dbg_state(st_a)
  );

  pos_sweep_ctrl #(.SETTLE_CYC(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort),
    .S1(s1_b), .S2(s2_b), .X(x_b), .Y(y_b), .Z(z_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .fail_vec(fv_b), .o_dbg_state(st_b)
  );

  // PoS datapath models: golden function plus optional faults on A.
  always_comb begin
    logic g1, g2;
    g1   = x_a ^ y_a ^ z_a;
    g2   = ~(y_a ^ z_a);
    s1_a = g1;
    s2_a = g2;
    case (mode)
      1: s2_a = 1'b0;                                  // S2 stuck-at-0
      2: if ({x_a, y_a, z_a} == 3'd5) s1_a = ~g1;      // S1 inverted on 101
      3: s1_a = 1'b1;                                  // S1 stuck-at-1
      4: begin s1_a = ~g1; s2_a = ~g2; end             // both always wrong
      5: if ({x_a, y_a, z_a} == 3'd7) s2_a = ~g2;      // S2 wrong on last vector
      default: ;
    endcase
  end

  assign s1_b = x_b ^ y_b ^ z_b;
  assign s2_b = ~(y_b ^ z_b);

  // Selected-instance view used by the sweep task.
  logic [2:0] m_xyz;
  logic       m_busy, m_done, m_pass;
  logic [3:0] m_err;
  logic [7:0] m_fv;
  assign m_xyz  = (sel != 0) ? {x_b, y_b, z_b} : {x_a, y_a, z_a};
  assign m_busy = (sel != 0) ? busy_b : busy_a;
  assign m_done = (sel != 0) ? done_b : done_a;
  assign m_pass = (sel != 0) ? pass_b : pass_a;
  assign m_err  = (sel != 0) ? err_b  : err_a;
  assign m_fv   = (sel != 0) ? fv_b   : fv_a;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Full sweep on the selected instance; X/Y/Z, busy and done checked every cycle.
  // n counts rising edges after the accepting edge; sampling is at the falling edge.
  task automatic run_sweep(input int s, input logic [7:0] efv, input logic [3:0] eerr,
                           input logic epass);
    int total;
    int k;
    total = 8 * (s + 1);
    @(negedge clk);
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("busy_on_accept", 32'(m_busy), 32'd1);
    chk("xyz_on_accept", 32'(m_xyz), 32'd0);
    for (int n = 1; n <= total + 1; n++) begin
      @(negedge clk);
      k = n / (s + 1);
      if (k > 7) k = 7;
      chk("xyz_step", 32'(m_xyz), 32'(k));
      chk("done_timing", 32'(m_done), 32'(n == total));
      chk("busy", 32'(m_busy), 32'(n <= total));
      if (n == total) chk("pass_at_done", 32'(m_pass), 32'(epass));
    end
    chk("pass_held", 32'(m_pass), 32'(epass));
    chk("err_cnt", 32'(m_err), 32'(eerr));
    chk("fail_vec", 32'(m_fv), 32'(efv));
  endtask

  typedef struct {
    int         mode;
    logic [7:0] fv;
    logic [3:0] err;
    logic       pass;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcount;
    // Expected fail_vec values follow from S1 = X^Y^Z and S2 = ~(Y^Z):
    // S2 = 1 on vectors 0,3,4,7; S1 = 1 on vectors 1,2,4,7.
    tbl[0] = '{0, 8'h00, 4'd0, 1'b1};
    tbl[1] = '{1, 8'h99, 4'd4, 1'b0};
    tbl[2] = '{2, 8'h20, 4'd1, 1'b0};
    tbl[3] = '{0, 8'h00, 4'd0, 1'b1};
    tbl[4] = '{3, 8'h69, 4'd4, 1'b0};
    tbl[5] = '{4, 8'hFF, 4'd8, 1'b0};
    tbl[6] = '{5, 8'h80, 4'd1, 1'b0};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
    mode = 0; sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_xyz_a", 32'({x_a, y_a, z_a}), 32'd0);
    chk("rst_flags_a", 32'({busy_a, done_a, pass_a}), 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    chk("rst_fv_a", 32'(fv_a), 32'd0);
    chk("rst_state_a", 32'(st_a), 32'd0);
    chk("rst_flags_b", 32'({busy_b, done_b, pass_b, x_b, y_b, z_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven full sweeps on A.
    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].mode;
      run_sweep(1, tbl[i].fv, tbl[i].err, tbl[i].pass);
    end

    // Abort during vector 3 CHECK; start pulse while busy ignored.
    mode = 1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (n == 3) start_a = 1'b1;
      if (n == 4) begin
        start_a = 1'b0;
        chk("start_while_busy_ignored", 32'({x_a, y_a, z_a}), 32'd2);
      end
    end
    chk("pre_abort_state", 32'(st_a), 32'd2);
    chk("pre_abort_fv", 32'(fv_a), 32'h01);
    chk("pre_abort_err", 32'(err_a), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 32'(st_a), 32'd0);
    chk("abort_busy_done_pass", 32'({busy_a, done_a, pass_a}), 32'd0);
    chk("abort_fv_kept", 32'(fv_a), 32'h01);
    chk("abort_err_kept", 32'(err_a), 32'd1);
    chk("abort_xyz_held", 32'({x_a, y_a, z_a}), 32'd3);
    dcount = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);

    // start and abort together in IDLE: abort wins.
    start_a = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", 32'(busy_a), 32'd0);
    chk("start_abort_idle_state", 32'(st_a), 32'd0);

    // SETTLE_CYC = 4 instance: 5 cycles per vector, done 40 edges after accept.
    sel = 1;
    run_sweep(4, 8'h00, 4'd0, 1'b1);
    sel = 0;

    // Asynchronous reset during vector 5.
    mode = 1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_err", 32'(err_a), 32'd3);
    chk("pre_reset_fv", 32'(fv_a), 32'h19);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_xyz", 32'({x_a, y_a, z_a}), 32'd0);
    chk("async_rst_flags", 32'({busy_a, done_a, pass_a}), 32'd0);
    chk("async_rst_err", 32'(err_a), 32'd0);
    chk("async_rst_fv", 32'(fv_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_a) dcount++;
    end
    chk("reset_no_done", 32'(dcount), 32'd0);
    mode = 0;
    run_sweep(1, 8'h00, 4'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
